// File: rtl/regfile_wb_queue.sv
// Write-back staging queue ahead of the register file's single write port.
// Optional forwarding of the youngest queued data is enabled by WBQ_BYPASS_EN.
module regfile_wb_queue #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = $clog2(QDEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             we0,
  output logic [AW-1:0]    wr_addr0,
  output logic [WIDTH-1:0] wr_din0,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic             hz0,
  output logic             hz1,
`ifdef WBQ_BYPASS_EN
  output logic [WIDTH-1:0] fwd_data0,
  output logic [WIDTH-1:0] fwd_data1,
`endif
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    r_addr [QDEPTH];
  logic [WIDTH-1:0] r_data [QDEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic [CW-1:0]     w_free;
  logic              w_a_push;
  logic              w_b_push;
  logic              w_pop;
  logic [PW-1:0]     w_b_slot;
  logic [QDEPTH-1:0] w_live;
  logic [QDEPTH-1:0] w_hit0;
  logic [QDEPTH-1:0] w_hit1;

  // Readiness looks only at registered occupancy; a slot freed by this cycle's pop is not reused.
  assign w_free   = CW'(QDEPTH) - r_count;
  assign a_ready  = !rst && (w_free >= CW'(1));
  assign b_ready  = !rst && ((w_free >= CW'(2)) || ((w_free >= CW'(1)) && !a_valid));
  assign w_a_push = a_valid && a_ready && (a_addr != '0);
  assign w_b_push = b_valid && b_ready && (b_addr != '0);
  assign w_pop    = (r_count != '0);
  assign w_b_slot = w_a_push ? r_tail + PW'(1) : r_tail;

  // Write port is suppressed during reset so flushed entries never land in the register file.
  assign we0      = w_pop && !rst;
  assign wr_addr0 = w_pop ? r_addr[r_head] : '0;
  assign wr_din0  = w_pop ? r_data[r_head] : '0;
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_a_push) + PW'(w_b_push);
      r_count <= r_count + CW'(w_a_push) + CW'(w_b_push) - CW'(w_pop);
    end
  end

  // A is older than B, so it takes the tail slot first.
  always_ff @(posedge clk) begin
    if (w_a_push) begin
      r_addr[r_tail] <= a_addr;
      r_data[r_tail] <= a_data;
    end
    if (w_b_push) begin
      r_addr[w_b_slot] <= b_addr;
      r_data[w_b_slot] <= b_data;
    end
  end

  always_comb begin : p_match
    logic [PW-1:0] v_age;
    w_live = '0;
    w_hit0 = '0;
    w_hit1 = '0;
    v_age  = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      v_age     = PW'(i) - r_head;
      w_live[i] = ({1'b0, v_age} < r_count);
      w_hit0[i] = w_live[i] && (r_addr[i] == rd_addr0);
      w_hit1[i] = w_live[i] && (r_addr[i] == rd_addr1);
    end
  end

  assign hz0 = (rd_addr0 != '0) && (|w_hit0);
  assign hz1 = (rd_addr1 != '0) && (|w_hit1);

`ifdef WBQ_BYPASS_EN
  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin : p_fwd
    logic [PW-1:0] v_idx;
    fwd_data0 = '0;
    fwd_data1 = '0;
    v_idx     = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      v_idx = r_head + PW'(k);
      if (hz0 && w_hit0[v_idx]) fwd_data0 = r_data[v_idx];
      if (hz1 && w_hit1[v_idx]) fwd_data1 = r_data[v_idx];
    end
  end
`endif

endmodule
